sipo_nbit_rx: RTL and testbench

Serial-to-parallel receiver that consumes the 1-bit stream from the N-bit PISO serializer and reassembles N-bit words. It counts sampled bits, publishes each completed word in a holding register with a valid flag, and takes an acknowledge from the parallel consumer. Lost words are reported by a sticky overrun flag. Together with the PISO it forms the loopback pair for the register-chapter benches.

---
 rtl/sipo_nbit_rx_pkg.sv | 29 ++
 rtl/sipo_nbit_rx_shift.sv | 77 +++++++
 rtl/sipo_nbit_rx.sv | 62 ++++++
 tb/tb_sipo_nbit_rx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sipo_nbit_rx_pkg.sv
// Shared register-chapter definitions for the serial receiver:
// counter width derivation and the receive phase encoding.
package sipo_nbit_rx_pkg;

  // Ceiling log2 evaluated at elaboration time; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  // Bit counter width for an N-bit word; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Receive phase: IDLE at a word boundary, SHIFT while a word is partial.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_phase_e;

endpackage

// File: rtl/sipo_nbit_rx_shift.sv
// Shift core: serial shift register, bit counter and word-completion detect.
// The assembled word presented on 'word' already includes the bit being
// sampled on the current edge, so the wrapper can capture it on that edge.
module sipo_shift_core
  import sipo_nbit_rx_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         d,
  input  logic         clr,
  output logic [N-1:0] word,
  output logic         wrap,
  output logic         busy
);

  localparam int unsigned       CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(N - 1);

  logic [N-1:0]     sreg;
  logic [N-1:0]     sreg_nxt;
  logic [N-1:0]     shifted;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  rx_phase_e        phase;

  // Shift register contents after accepting d on this edge.
  always_comb begin
    shifted = sreg;
    if (MSB_FIRST) begin
      shifted = {sreg[N-2:0], d};
    end else begin
      shifted = {d, sreg[N-1:1]};
    end
  end

  // Next-state: clear beats sampling; the counter wraps on the N-th bit.
  always_comb begin
    sreg_nxt = sreg;
    cnt_nxt  = cnt;
    wrap     = 1'b0;
    if (clr) begin
      sreg_nxt = '0;
      cnt_nxt  = '0;
    end else if (en) begin
      sreg_nxt = shifted;
      if (cnt == LAST) begin
        cnt_nxt = '0;
        wrap    = 1'b1;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else begin
      sreg <= sreg_nxt;
      cnt  <= cnt_nxt;
    end
  end

  // Phase decode straight from the counter register.
  always_comb begin
    phase = (cnt == '0) ? ST_IDLE : ST_SHIFT;
    busy  = (phase == ST_SHIFT);
    word  = shifted;
  end

endmodule

// File: rtl/sipo_nbit_rx.sv
// Serial-to-parallel receiver: reassembles N-bit words from a 1-bit stream,
// holds the last completed word with a valid/ack handshake and reports
// words lost to an unacknowledged holding register via a sticky overrun.
module sipo_nbit_rx
  import sipo_nbit_rx_pkg::*;
#(
  parameter int unsigned N         = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic         en_in,
  input  logic         d_in,
  input  logic         clr_in,
  input  logic         ack_in,
  output logic [N-1:0] q_out,
  output logic         valid_out,
  output logic         overrun_out,
  output logic         busy_out
);

  logic [N-1:0] word;
  logic         done;

  sipo_shift_core #(
    .N         (N),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .clk   (clk),
    .rst_n (reset_al_in),
    .en    (en_in),
    .d     (d_in),
    .clr   (clr_in),
    .word  (word),
    .wrap  (done),
    .busy  (busy_out)
  );

  // Holding register with handshake; a completion outranks a same-edge ack
  // and clr never coincides with a completion because it blocks sampling.
  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      q_out       <= '0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      if (done) begin
        q_out     <= word;
        valid_out <= 1'b1;
        if (valid_out && !ack_in) begin
          overrun_out <= 1'b1;
        end
      end else if (ack_in) begin
        valid_out <= 1'b0;
      end
      if (clr_in) begin
        overrun_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_nbit_rx.sv
// Bench for sipo_nbit_rx: two instances (N=4 MSB-first, N=8 LSB-first) share
// the same stimulus; a bit-list reference model predicts each cycle's
// outputs into per-instance queues drained by independent monitors.
module tb_sipo_nbit_rx;

  typedef struct packed {
    logic [7:0] q;
    logic       valid;
    logic       ovr;
    logic       busy;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       d;
  logic       clr;
  logic       ack;
  logic [3:0] q4;
  logic       v4, o4, b4;
  logic [7:0] q8;
  logic       v8, o8, b8;

  int vectors     = 0;
  int miscompares = 0;

  exp_t eq0[$];
  exp_t eq1[$];

  logic [7:0]  m_q[2];
  bit          m_v[2];
  bit          m_o[2];
  int unsigned m_cnt[2];
  bit          m_bits[2][8];

  sipo_nbit_rx #(.N(4), .MSB_FIRST(1'b1)) u4 (
    .clk(clk), .reset_al_in(rst_n), .en_in(en), .d_in(d), .clr_in(clr),
    .ack_in(ack), .q_out(q4), .valid_out(v4), .overrun_out(o4), .busy_out(b4)
  );

  sipo_nbit_rx #(.N(8), .MSB_FIRST(1'b0)) u8 (
    .clk(clk), .reset_al_in(rst_n), .en_in(en), .d_in(d), .clr_in(clr),
    .ack_in(ack), .q_out(q8), .valid_out(v8), .overrun_out(o8), .busy_out(b8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] assemble(input int u, input int unsigned n);
    logic [7:0] w;
    w = 8'h00;
    for (int unsigned i = 0; i < n; i++) begin
      if (m_bits[u][i]) begin
        // unit 0 is MSB-first: first bit carries weight 2^(n-1)
        w = w + 8'((u == 0) ? (1 << (n - 1 - i)) : (1 << i));
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_q[u] = 8'h00; m_v[u] = 0; m_o[u] = 0; m_cnt[u] = 0;
    end
  endtask

  task automatic model_update(input int u, input bit e, input bit dd, input bit c, input bit a);
    int unsigned n;
    bit   done;
    exp_t x;
    n    = (u == 0) ? 4 : 8;
    done = 0;
    if (c) begin
      m_cnt[u] = 0;
      m_o[u]   = 0;
    end else if (e) begin
      m_bits[u][m_cnt[u]] = dd;
      m_cnt[u]++;
      if (m_cnt[u] == n) begin
        done     = 1;
        m_cnt[u] = 0;
      end
    end
    if (done) begin
      if (m_v[u] && !a) m_o[u] = 1;
      m_q[u] = assemble(u, n);
      m_v[u] = 1;
    end else if (a) begin
      m_v[u] = 0;
    end
    x.q = m_q[u]; x.valid = m_v[u]; x.ovr = m_o[u]; x.busy = (m_cnt[u] != 0);
    if (u == 0) eq0.push_back(x);
    else        eq1.push_back(x);
  endtask

  // One clock of stimulus; returns 1 time unit after the sampling edge.
  task automatic step(input bit e, input bit dd, input bit c, input bit a);
    @(negedge clk);
    en  = e;
    d   = e ? dd : 1'($urandom);
    clr = c;
    ack = a;
    model_update(0, e, dd, c, a);
    model_update(1, e, dd, c, a);
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n, input bit ack_last, input int gap);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, w[i], 1'b0, ack_last && (i == 0));
      if (i > 0) repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    en = 0; clr = 0; ack = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst q4", q4, 0); chk("rst v4", v4, 0); chk("rst o4", o4, 0); chk("rst b4", b4, 0);
    chk("rst q8", q8, 0); chk("rst v8", v8, 0); chk("rst o8", o8, 0); chk("rst b8", b8, 0);
    #1 rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor for the N=4 instance.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (eq0.size() > 0) begin
        x = eq0.pop_front();
        chk("u4 q_out", q4, x.q[3:0]);
        chk("u4 valid_out", v4, x.valid);
        chk("u4 overrun_out", o4, x.ovr);
        chk("u4 busy_out", b4, x.busy);
      end
    end
  end

  // Monitor for the N=8 instance.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (eq1.size() > 0) begin
        x = eq1.pop_front();
        chk("u8 q_out", q8, x.q);
        chk("u8 valid_out", v8, x.valid);
        chk("u8 overrun_out", o8, x.ovr);
        chk("u8 busy_out", b8, x.busy);
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 0; d = 0; clr = 0; ack = 0;
    model_reset();
    #3;
    chk("init q4", q4, 0); chk("init v4", v4, 0); chk("init b4", b4, 0); chk("init o4", o4, 0);
    #9 rst_n = 1'b1;

    // Reset mid-word discards the partial word.
    step(1, 1, 0, 0);
    step(1, 0, 0, 0);
    async_reset();
    send_bits(8'b1101, 4, 0, 0);
    chk("restart q4", q4, 4'b1101);
    chk("restart v4", v4, 1);
    step(0, 0, 0, 1);

    // MSB-first N=4 with busy tracking.
    step(1, 1, 0, 0); chk("busy e1", b4, 1);
    step(1, 0, 0, 0); chk("busy e2", b4, 1);
    step(1, 1, 0, 0); chk("busy e3", b4, 1);
    step(1, 1, 0, 0); chk("busy e4", b4, 0);
    chk("msb q4", q4, 4'd11);
    chk("msb v4", v4, 1);
    step(0, 0, 0, 1);

    // Loopback-style words 11 then 13 with a 200 ns gap and ack in between.
    send_bits(8'd11, 4, 0, 0);
    repeat (20) step(0, 0, 0, 0);
    chk("loop w1", q4, 4'd11);
    step(0, 0, 0, 1);
    send_bits(8'd13, 4, 0, 0);
    chk("loop w2", q4, 4'd13);
    chk("loop ovr", o4, 0);
    step(0, 0, 0, 1);

    // Overrun, then ack racing a completion, then clear.
    send_bits(8'b1011, 4, 0, 0);
    send_bits(8'b0110, 4, 0, 0);
    chk("ovr q4", q4, 4'b0110);
    chk("ovr set", o4, 1);
    send_bits(8'b0001, 4, 1, 0);
    chk("race q4", q4, 4'b0001);
    chk("race v4", v4, 1);
    chk("race ovr", o4, 1);
    step(0, 0, 1, 0);
    chk("clr ovr", o4, 0);
    chk("clr keeps v4", v4, 1);
    step(0, 0, 0, 1);

    // Clear mid-word drops the bit on that edge.
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    chk("clr busy", b4, 0);
    chk("clr q4 held", q4, 4'b0001);
    send_bits(8'b0101, 4, 0, 0);
    chk("post clr q4", q4, 4'b0101);
    step(0, 0, 0, 1);

    // LSB-first N=8, back-to-back then with 3-cycle gaps.
    step(0, 0, 1, 1);
    send_bits(8'h80, 8, 0, 0);
    chk("lsb q8", q8, 8'h01);
    chk("lsb v8", v8, 1);
    step(0, 0, 0, 1);
    send_bits(8'h80, 8, 0, 3);
    chk("gap q8", q8, 8'h01);
    chk("gap v8", v8, 1);

    // Randomised traffic, with one asynchronous reset midway.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_reset();
      step($urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 29) == 0,
           $urandom_range(0, 4) == 0);
    end

    repeat (3) @(posedge clk);
    #3;
    chk("u4 queue drained", eq0.size(), 0);
    chk("u8 queue drained", eq1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
